// File: rtl/int_result_buffer_if.sv
// Handshake and control bundle between the ALU/pipeline side (master) and int_result_buffer (slave).
interface int_result_buffer_if #(
    parameter int SPEC_STATES     = 4,
    parameter int RESULT_LEN      = 32,
    parameter int WAKEUP_RESP_LEN = 8
);
    logic                       Flush;
    logic                       Kill_Enable;
    logic [SPEC_STATES-1:0]     Kill_VKillMask;
    logic                       Resolve_Enable;
    logic [SPEC_STATES-1:0]     Resolve_Mask;
    logic                       In_Valid;
    logic [RESULT_LEN-1:0]      In_ResultBus;
    logic [WAKEUP_RESP_LEN-1:0] In_WakeupResp;
    logic [SPEC_STATES-1:0]     In_KillMask;
    logic                       In_Ready;
    logic                       Out_Valid;
    logic [RESULT_LEN-1:0]      Out_ResultBus;
    logic [WAKEUP_RESP_LEN-1:0] Out_WakeupResp;
    logic                       Out_Grant;

    modport master (
        output Flush, Kill_Enable, Kill_VKillMask, Resolve_Enable, Resolve_Mask,
        output In_Valid, In_ResultBus, In_WakeupResp, In_KillMask, Out_Grant,
        input  In_Ready, Out_Valid, Out_ResultBus, Out_WakeupResp
    );

    modport slave (
        input  Flush, Kill_Enable, Kill_VKillMask, Resolve_Enable, Resolve_Mask,
        input  In_Valid, In_ResultBus, In_WakeupResp, In_KillMask, Out_Grant,
        output In_Ready, Out_Valid, Out_ResultBus, Out_WakeupResp
    );
endinterface

// File: rtl/int_result_buffer.sv
// In-order result FIFO between the integer ALU and the writeback/wakeup arbiter, with kill/resolve/flush.
// Optional same-cycle bypass of an empty buffer is enabled by defining RESULT_BUF_BYPASS_EN.
module int_result_buffer #(
    parameter int DEPTH           = 2,
    parameter int PTR_W           = 1,
    parameter int SPEC_STATES     = 4,
    parameter int RESULT_LEN      = 32,
    parameter int WAKEUP_RESP_LEN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    int_result_buffer_if.slave  bus
);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [SPEC_STATES-1:0]     kmask_q  [DEPTH];
    logic [SPEC_STATES-1:0]     kmask_d  [DEPTH];
    logic [RESULT_LEN-1:0]      result_q [DEPTH];
    logic [WAKEUP_RESP_LEN-1:0] wakeup_q [DEPTH];
    logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;

    logic                       in_ready;
    logic                       kill_in;
    logic                       push_ok;
    logic                       head_kill;
    logic                       head_live;
    logic                       empty;
    logic                       pop;
    logic                       write_en;
    logic [SPEC_STATES-1:0]     res_clr;
`ifdef RESULT_BUF_BYPASS_EN
    logic                       bypass;
`endif

    // In_Ready looks only at the registered count, so a same-cycle pop never frees a slot for a push.
    assign in_ready     = (count_q != FULL_CNT);
    assign bus.In_Ready = in_ready;

    // NOTE: every always_comb output gets a default at the top so no path can infer a latch.
    always_comb begin
        empty     = (count_q == '0);
        kill_in   = bus.Kill_Enable & |(bus.In_KillMask & bus.Kill_VKillMask);
        push_ok   = bus.In_Valid & in_ready & ~bus.Flush & ~kill_in;
        head_kill = bus.Kill_Enable & |(kmask_q[head_q] & bus.Kill_VKillMask);
        head_live = valid_q[head_q] & ~head_kill & ~bus.Flush;
        pop       = (head_live & bus.Out_Grant) | (~empty & ~valid_q[head_q]);
`ifdef RESULT_BUF_BYPASS_EN
        bypass    = empty & push_ok;
        write_en  = push_ok & ~(bypass & bus.Out_Grant);
`else
        write_en  = push_ok;
`endif

        bus.Out_Valid      = head_live;
        bus.Out_ResultBus  = head_live ? result_q[head_q] : '0;
        bus.Out_WakeupResp = head_live ? wakeup_q[head_q] : '0;
`ifdef RESULT_BUF_BYPASS_EN
        if (bypass) begin
            bus.Out_Valid      = 1'b1;
            bus.Out_ResultBus  = bus.In_ResultBus;
            bus.Out_WakeupResp = bus.In_WakeupResp;
        end
`endif
    end

    // Kill is evaluated against the pre-resolve masks held in kmask_q.
    always_comb begin
        res_clr = bus.Resolve_Enable ? bus.Resolve_Mask : '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i] & ~(bus.Kill_Enable & |(kmask_q[i] & bus.Kill_VKillMask));
            kmask_d[i] = kmask_q[i] & ~res_clr;
        end
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(write_en);
        count_d = count_q;

        if (pop) valid_d[head_q] = 1'b0;
        if (write_en) begin
            valid_d[tail_q] = 1'b1;
            kmask_d[tail_q] = bus.In_KillMask & ~res_clr;
        end

        case ({write_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.Flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: payload storage is not reset; an entry's contents are only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        kmask_q <= kmask_d;
        if (write_en) begin
            result_q[tail_q] <= bus.In_ResultBus;
            wakeup_q[tail_q] <= bus.In_WakeupResp;
        end
    end

`ifndef SYNTHESIS
    // Offering a result while the buffer is full drops it; a flush discards the input anyway.
    in_valid_while_full_a : assert property (
        @(posedge clk) disable iff (!rst_n || bus.Flush) !(bus.In_Valid && !bus.In_Ready)
    );
`endif
endmodule

// File: tb/tb_int_result_buffer.sv
// Directed self-checking bench for int_result_buffer; inputs change on the falling edge, outputs sampled 1 time unit later.
module tb_int_result_buffer;
    localparam int SPEC_STATES     = 4;
    localparam int RESULT_LEN      = 32;
    localparam int WAKEUP_RESP_LEN = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    int_result_buffer_if #(
        .SPEC_STATES(SPEC_STATES), .RESULT_LEN(RESULT_LEN), .WAKEUP_RESP_LEN(WAKEUP_RESP_LEN)
    ) bus ();

    int_result_buffer #(
        .DEPTH(2), .PTR_W(1),
        .SPEC_STATES(SPEC_STATES), .RESULT_LEN(RESULT_LEN), .WAKEUP_RESP_LEN(WAKEUP_RESP_LEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.Flush          = 1'b0;
        bus.Kill_Enable    = 1'b0;
        bus.Kill_VKillMask = '0;
        bus.Resolve_Enable = 1'b0;
        bus.Resolve_Mask   = '0;
        bus.In_Valid       = 1'b0;
        bus.In_ResultBus   = '0;
        bus.In_WakeupResp  = '0;
        bus.In_KillMask    = '0;
        bus.Out_Grant      = 1'b0;
    endtask

    task automatic drive_push(input logic [31:0] r, input logic [7:0] w, input logic [3:0] m);
        bus.In_Valid      = 1'b1;
        bus.In_ResultBus  = r;
        bus.In_WakeupResp = w;
        bus.In_KillMask   = m;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.Out_Valid); end
        vectors++; if (bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.In_Ready); end
        vectors++; if (bus.Out_ResultBus !== 32'h0) begin miscompares++; $display("FAIL reset_out_result: got %h expected 0", bus.Out_ResultBus); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_valid: got %b expected 0", bus.Out_Valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk); drive_push(32'hA, 8'h0A, 4'b0000); #1;
        vectors++; if (bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_empty: got %b expected 1", bus.In_Ready); end
        @(negedge clk); drive_push(32'hB, 8'h0B, 4'b0000); #1;
        vectors++; if (bus.Out_Valid !== 1'b1) begin miscompares++; $display("FAIL bp_a_valid: got %b expected 1", bus.Out_Valid); end
        vectors++; if (bus.Out_ResultBus !== 32'hA) begin miscompares++; $display("FAIL bp_a_result: got %h expected a", bus.Out_ResultBus); end
        vectors++; if (bus.Out_WakeupResp !== 8'h0A) begin miscompares++; $display("FAIL bp_a_wakeup: got %h expected 0a", bus.Out_WakeupResp); end
        @(negedge clk); bus.In_Valid = 1'b0; #1;
        vectors++; if (bus.In_Ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready: got %b expected 0", bus.In_Ready); end
        vectors++; if (bus.Out_ResultBus !== 32'hA) begin miscompares++; $display("FAIL bp_hold_a: got %h expected a", bus.Out_ResultBus); end
        bus.Out_Grant = 1'b1;
        @(negedge clk); #1;
        vectors++; if (bus.Out_Valid !== 1'b1 || bus.Out_ResultBus !== 32'hB) begin miscompares++; $display("FAIL bp_b_next: got v=%b r=%h expected v=1 r=b", bus.Out_Valid, bus.Out_ResultBus); end
        vectors++; if (bus.Out_WakeupResp !== 8'h0B) begin miscompares++; $display("FAIL bp_b_wakeup: got %h expected 0b", bus.Out_WakeupResp); end
        vectors++; if (bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after_pop: got %b expected 1", bus.In_Ready); end
        @(negedge clk); bus.Out_Grant = 1'b0; #1;
        vectors++; if (bus.Out_Valid !== 1'b0 || bus.Out_ResultBus !== 32'h0) begin miscompares++; $display("FAIL bp_drained: got v=%b r=%h expected v=0 r=0", bus.Out_Valid, bus.Out_ResultBus); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk); drive_push(32'hC1, 8'hC1, 4'b0000);
        @(negedge clk); drive_push(32'hC2, 8'hC2, 4'b0000);
        @(negedge clk); bus.In_Valid = 1'b0; #1;
        vectors++; if (bus.In_Ready !== 1'b0) begin miscompares++; $display("FAIL mid_full_before_reset: got %b expected 0", bus.In_Ready); end
        rst_n = 1'b0; #1;
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_out_valid: got %b expected 0", bus.Out_Valid); end
        vectors++; if (bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_in_ready: got %b expected 1", bus.In_Ready); end
        vectors++; if (bus.Out_ResultBus !== 32'h0) begin miscompares++; $display("FAIL mid_reset_out_result: got %h expected 0", bus.Out_ResultBus); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        vectors++; if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL mid_after_release: got v=%b rdy=%b expected v=0 rdy=1", bus.Out_Valid, bus.In_Ready); end
    endtask

    task automatic test_kill();
        @(negedge clk); drive_push(32'h11, 8'h11, 4'b0001);
        @(negedge clk); drive_push(32'h22, 8'h22, 4'b0010);
        @(negedge clk); bus.In_Valid = 1'b0; bus.Kill_Enable = 1'b1; bus.Kill_VKillMask = 4'b0001; #1;
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL kill_head_masked: got %b expected 0", bus.Out_Valid); end
        @(negedge clk); bus.Kill_Enable = 1'b0; bus.Kill_VKillMask = '0; #1;
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL kill_dead_head: got %b expected 0", bus.Out_Valid); end
        vectors++; if (bus.In_Ready !== 1'b0) begin miscompares++; $display("FAIL kill_slot_occupied: got %b expected 0", bus.In_Ready); end
        @(negedge clk); #1;
        vectors++; if (bus.Out_Valid !== 1'b1 || bus.Out_ResultBus !== 32'h22) begin miscompares++; $display("FAIL kill_survivor: got v=%b r=%h expected v=1 r=22", bus.Out_Valid, bus.Out_ResultBus); end
        bus.Out_Grant = 1'b1;
        @(negedge clk); bus.Out_Grant = 1'b0; #1;
        vectors++; if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL kill_drained: got v=%b rdy=%b expected v=0 rdy=1", bus.Out_Valid, bus.In_Ready); end
    endtask

    task automatic test_resolve();
        // Stored mask resolved, then killed on the next cycle: the entry survives.
        @(negedge clk); drive_push(32'h33, 8'h33, 4'b0100);
        @(negedge clk); bus.In_Valid = 1'b0; bus.Resolve_Enable = 1'b1; bus.Resolve_Mask = 4'b0100;
        @(negedge clk); bus.Resolve_Enable = 1'b0; bus.Resolve_Mask = '0;
        bus.Kill_Enable = 1'b1; bus.Kill_VKillMask = 4'b0100; bus.Out_Grant = 1'b1; #1;
        vectors++; if (bus.Out_Valid !== 1'b1 || bus.Out_ResultBus !== 32'h33) begin miscompares++; $display("FAIL resolve_stored_survives: got v=%b r=%h expected v=1 r=33", bus.Out_Valid, bus.Out_ResultBus); end
        @(negedge clk); idle(); #1;
        vectors++; if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL resolve_granted: got v=%b rdy=%b expected v=0 rdy=1", bus.Out_Valid, bus.In_Ready); end
        // Resolve in the push cycle clears the bit before it is stored.
        @(negedge clk); drive_push(32'h44, 8'h44, 4'b0100); bus.Resolve_Enable = 1'b1; bus.Resolve_Mask = 4'b0100;
        @(negedge clk); idle(); bus.Kill_Enable = 1'b1; bus.Kill_VKillMask = 4'b0100; #1;
        vectors++; if (bus.Out_Valid !== 1'b1 || bus.Out_ResultBus !== 32'h44) begin miscompares++; $display("FAIL resolve_push_survives: got v=%b r=%h expected v=1 r=44", bus.Out_Valid, bus.Out_ResultBus); end
        bus.Out_Grant = 1'b1;
        @(negedge clk); idle();
        // Resolve and kill together: kill sees the pre-resolve mask.
        @(negedge clk); drive_push(32'h66, 8'h66, 4'b0100);
        @(negedge clk); idle(); bus.Resolve_Enable = 1'b1; bus.Resolve_Mask = 4'b0100;
        bus.Kill_Enable = 1'b1; bus.Kill_VKillMask = 4'b0100; #1;
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL resolve_kill_same_cycle: got %b expected 0", bus.Out_Valid); end
        @(negedge clk); idle(); #1;
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL resolve_kill_dead: got %b expected 0", bus.Out_Valid); end
        @(negedge clk); #1;
        vectors++; if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL resolve_kill_skipped: got v=%b rdy=%b expected v=0 rdy=1", bus.Out_Valid, bus.In_Ready); end
    endtask

    task automatic test_flush();
        @(negedge clk); drive_push(32'h71, 8'h71, 4'b0000);
        @(negedge clk); drive_push(32'h72, 8'h72, 4'b0000);
        @(negedge clk); drive_push(32'h73, 8'h73, 4'b0000); bus.Out_Grant = 1'b1; bus.Flush = 1'b1; #1;
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL flush_cycle_out_valid: got %b expected 0", bus.Out_Valid); end
        @(negedge clk); idle(); #1;
        vectors++; if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL flush_emptied: got v=%b rdy=%b expected v=0 rdy=1", bus.Out_Valid, bus.In_Ready); end
        @(negedge clk); drive_push(32'h74, 8'h74, 4'b0000);
        @(negedge clk); bus.In_Valid = 1'b0; #1;
        vectors++; if (bus.Out_Valid !== 1'b1 || bus.Out_ResultBus !== 32'h74) begin miscompares++; $display("FAIL flush_then_push: got v=%b r=%h expected v=1 r=74", bus.Out_Valid, bus.Out_ResultBus); end
        vectors++; if (bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL flush_count_one: got %b expected 1", bus.In_Ready); end
        bus.Out_Grant = 1'b1;
        @(negedge clk); idle(); #1;
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL flush_final_drain: got %b expected 0", bus.Out_Valid); end
    endtask

    task automatic test_bypass();
        @(negedge clk); drive_push(32'h55, 8'h55, 4'b0000); bus.Out_Grant = 1'b1; #1;
`ifdef RESULT_BUF_BYPASS_EN
        vectors++; if (bus.Out_Valid !== 1'b1 || bus.Out_ResultBus !== 32'h55) begin miscompares++; $display("FAIL bypass_same_cycle: got v=%b r=%h expected v=1 r=55", bus.Out_Valid, bus.Out_ResultBus); end
`else
        vectors++; if (bus.Out_Valid !== 1'b0) begin miscompares++; $display("FAIL nobypass_same_cycle: got %b expected 0", bus.Out_Valid); end
`endif
        @(negedge clk); bus.In_Valid = 1'b0; #1;
`ifdef RESULT_BUF_BYPASS_EN
        vectors++; if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL bypass_not_stored: got v=%b rdy=%b expected v=0 rdy=1", bus.Out_Valid, bus.In_Ready); end
`else
        vectors++; if (bus.Out_Valid !== 1'b1 || bus.Out_ResultBus !== 32'h55) begin miscompares++; $display("FAIL nobypass_next_cycle: got v=%b r=%h expected v=1 r=55", bus.Out_Valid, bus.Out_ResultBus); end
`endif
        @(negedge clk); idle(); #1;
        vectors++; if (bus.Out_Valid !== 1'b0 || bus.In_Ready !== 1'b1) begin miscompares++; $display("FAIL bypass_final_empty: got v=%b rdy=%b expected v=0 rdy=1", bus.Out_Valid, bus.In_Ready); end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_reset_midstream();
        test_kill();
        test_resolve();
        test_flush();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
